// File: rtl/walk_pkg.sv
// rtl/walk_pkg.sv - shared widths, FSM state and request record for the walk request queue
package walk_pkg;

    localparam int VA_W     = 32;
    localparam int PA_W     = 32;
    localparam int REQ_ID_W = 4;

    typedef enum logic [1:0] {
        ISSUE,
        WAIT,
        RESP
    } walk_q_state_e;

    typedef struct packed {
        logic [VA_W-1:0]     va;
        logic [REQ_ID_W-1:0] id;
    } walk_req_t;

endpackage

// File: rtl/walk_req_queue_if.sv
// rtl/walk_req_queue_if.sv - request, walker and response handshakes of the walk request queue
interface walk_req_queue_if #(
    parameter int ID_W = 4
) ();

    logic [walk_pkg::VA_W-1:0] req_va_i;
    logic [ID_W-1:0]           req_id_i;
    logic                      req_vld_i;
    logic                      req_rdy_o;

    logic [walk_pkg::VA_W-1:0] wk_va_o;
    logic                      wk_va_vld_o;
    logic                      wk_va_rdy_i;
    logic                      wk_stall_i;
    logic [walk_pkg::PA_W-1:0] wk_pa_i;
    logic                      wk_pa_vld_i;
    logic                      wk_pa_fault_i;
    logic                      wk_pa_rdy_o;

    logic [walk_pkg::PA_W-1:0] rsp_pa_o;
    logic [ID_W-1:0]           rsp_id_o;
    logic                      rsp_fault_o;
    logic                      rsp_vld_o;
    logic                      rsp_rdy_i;

    modport slave (
        input  req_va_i, req_id_i, req_vld_i,
        output req_rdy_o,
        output wk_va_o, wk_va_vld_o,
        input  wk_va_rdy_i, wk_stall_i, wk_pa_i, wk_pa_vld_i, wk_pa_fault_i,
        output wk_pa_rdy_o,
        output rsp_pa_o, rsp_id_o, rsp_fault_o, rsp_vld_o,
        input  rsp_rdy_i
    );

    modport master (
        output req_va_i, req_id_i, req_vld_i,
        input  req_rdy_o,
        input  wk_va_o, wk_va_vld_o,
        output wk_va_rdy_i, wk_stall_i, wk_pa_i, wk_pa_vld_i, wk_pa_fault_i,
        input  wk_pa_rdy_o,
        input  rsp_pa_o, rsp_id_o, rsp_fault_o, rsp_vld_o,
        output rsp_rdy_i
    );

endinterface

// File: rtl/walk_req_fifo.sv
// rtl/walk_req_fifo.sv - synchronous FIFO of walk requests; caller never pushes when full or pops when empty
module walk_req_fifo
    import walk_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  walk_req_t                    data_i,
    input  logic                         pop_i,
    output walk_req_t                    data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    walk_req_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/walk_req_queue.sv
// rtl/walk_req_queue.sv - single-outstanding request front-end for the page-table walker
// Optional watchdog on the walker result: WALK_REQ_TIMEOUT_EN.
module walk_req_queue
    import walk_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ID_W        = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    walk_req_queue_if.slave            bus,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o,
    output logic                       timeout_o
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT_CYC < 1)) begin : g_bad_cfg
        $error("walk_req_queue: DEPTH must be a power of two >= 2 and TIMEOUT_CYC >= 1");
    end

    walk_req_t       push_req, head_req;
    logic            full, empty, push, pop;
    walk_q_state_e   state_q, state_d;
    logic [ID_W-1:0] inflight_id_q, inflight_id_d, rsp_id_q, rsp_id_d;
    logic [PA_W-1:0] rsp_pa_q, rsp_pa_d;
    logic            rsp_fault_q, rsp_fault_d, rsp_vld_q, rsp_vld_d;
    logic            wk_va_vld, wk_pa_rdy;

    assign push_req = '{va: bus.req_va_i, id: REQ_ID_W'(bus.req_id_i)};
    assign push     = bus.req_vld_i && !full;

    walk_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_req),
        .pop_i   (pop),
        .data_o  (head_req),
        .full_o  (full),
        .empty_o (empty),
        .cnt_o   (cnt_o)
    );

`ifdef WALK_REQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            drop_q, drop_d, timeout_q, timeout_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_cnt_q  <= '0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            drop_q    <= drop_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic drop_q;
    assign drop_q    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ISSUE;
            inflight_id_q <= '0;
            rsp_pa_q      <= '0;
            rsp_id_q      <= '0;
            rsp_fault_q   <= 1'b0;
            rsp_vld_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            inflight_id_q <= inflight_id_d;
            rsp_pa_q      <= rsp_pa_d;
            rsp_id_q      <= rsp_id_d;
            rsp_fault_q   <= rsp_fault_d;
            rsp_vld_q     <= rsp_vld_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        inflight_id_d = inflight_id_q;
        rsp_pa_d      = rsp_pa_q;
        rsp_id_d      = rsp_id_q;
        rsp_fault_d   = rsp_fault_q;
        rsp_vld_d     = rsp_vld_q;
        wk_va_vld     = 1'b0;
        wk_pa_rdy     = 1'b0;
        pop           = 1'b0;
`ifdef WALK_REQ_TIMEOUT_EN
        wd_cnt_d      = '0;
        drop_d        = drop_q;
        timeout_d     = timeout_q;
`endif
        unique case (state_q)
            ISSUE: begin
                wk_va_vld = !empty && !bus.wk_stall_i && !drop_q;
`ifdef WALK_REQ_TIMEOUT_EN
                // A walk abandoned by the watchdog still owes one result; swallow it before issuing again.
                if (drop_q) begin
                    wk_pa_rdy = 1'b1;
                    if (bus.wk_pa_vld_i) drop_d = 1'b0;
                end
`endif
                if (wk_va_vld && bus.wk_va_rdy_i) begin
                    pop           = 1'b1;
                    inflight_id_d = ID_W'(head_req.id);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                wk_pa_rdy = 1'b1;
                if (bus.wk_pa_vld_i) begin
                    rsp_pa_d    = bus.wk_pa_i;
                    rsp_fault_d = bus.wk_pa_fault_i;
                    rsp_id_d    = inflight_id_q;
                    rsp_vld_d   = 1'b1;
                    state_d     = RESP;
                end
`ifdef WALK_REQ_TIMEOUT_EN
                else if (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    rsp_pa_d    = '0;
                    rsp_fault_d = 1'b1;
                    rsp_id_d    = inflight_id_q;
                    rsp_vld_d   = 1'b1;
                    timeout_d   = 1'b1;
                    drop_d      = 1'b1;
                    state_d     = RESP;
                end else begin
                    wd_cnt_d = wd_cnt_q + WD_W'(1);
                end
`endif
            end
            RESP: begin
                if (bus.rsp_rdy_i) begin
                    rsp_vld_d = 1'b0;
                    state_d   = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase
    end

    assign bus.req_rdy_o   = !full;
    assign bus.wk_va_o     = head_req.va;
    assign bus.wk_va_vld_o = wk_va_vld;
    assign bus.wk_pa_rdy_o = wk_pa_rdy;
    assign bus.rsp_pa_o    = rsp_pa_q;
    assign bus.rsp_id_o    = rsp_id_q;
    assign bus.rsp_fault_o = rsp_fault_q;
    assign bus.rsp_vld_o   = rsp_vld_q;

endmodule

// File: doc/walk_req_queue.md
Name: walk_req_queue

Overview:
- Request front-end directly upstream of the page-table walker.
- Buffers translation requests (VA plus requester ID) in a DEPTH-entry FIFO and issues them one at a time on the walker VA valid/ready interface.
- Consumes the walker PA/fault result and returns it, tagged with the original ID, on a response valid/ready interface.
- Exactly one walk is outstanding at any time, matching the walker's single-in-flight ready behaviour.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
ID_W, 4, requester ID width
TIMEOUT_CYC, 64, watchdog limit in cycles; used only with the optional feature

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
req_va_i  in  32  request virtual address
req_id_i  in  ID_W  request tag
req_vld_i  in  1  request valid
req_rdy_o  out  1  request ready; equals !full
wk_va_o  out  32  VA to walker, taken from the FIFO head
wk_va_vld_o  out  1  VA valid to walker
wk_va_rdy_i  in  1  walker ready
wk_stall_i  in  1  walker stall
wk_pa_i  in  32  walker PA
wk_pa_vld_i  in  1  walker PA valid
wk_pa_fault_i  in  1  walker fault
wk_pa_rdy_o  out  1  PA ready to walker
rsp_pa_o  out  32  returned PA
rsp_id_o  out  ID_W  returned tag
rsp_fault_o  out  1  returned fault
rsp_vld_o  out  1  response valid
rsp_rdy_i  in  1  response ready
cnt_o  out  $clog2(DEPTH+1)  FIFO occupancy
timeout_o  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_i high at a clock edge):
  - Pointers and count go to 0; FSM goes to ISSUE.
  - Response registers cleared: rsp_vld_o=0, rsp_pa_o=0, rsp_id_o=0, rsp_fault_o=0.
  - timeout_o=0 and the drop flag is cleared.
  - Reset mid-walk discards all queued and in-flight state; the walker is reset alongside.
- FIFO:
  - Push when req_vld_i && req_rdy_o; pop on the walker handshake.
  - Pointers wrap modulo DEPTH.
  - No bypass: a push into an empty FIFO is issuable the next cycle.
  - When full, req_rdy_o=0 even if a pop occurs in the same cycle.
  - Push and pop in the same cycle leave cnt_o unchanged.
- FSM states: ISSUE, WAIT, RESP.
  - ISSUE:
    - wk_va_vld_o = !empty && !wk_stall_i && !drop; wk_va_o = head VA.
    - Handshake is wk_va_vld_o && wk_va_rdy_i at the edge.
    - On handshake: pop, latch the head ID into an in-flight ID register, go to WAIT.
  - WAIT:
    - wk_pa_rdy_o = 1.
    - On wk_pa_vld_i: capture wk_pa_i and wk_pa_fault_i together with the in-flight ID into the response registers, set rsp_vld_o, go to RESP.
    - Any transfer received outside WAIT is ignored, except the drop-flag case below.
  - RESP:
    - rsp_* held stable while rsp_vld_o && !rsp_rdy_i.
    - On rsp_rdy_i: clear rsp_vld_o, go to ISSUE.
    - wk_pa_rdy_o = 0, so the walker stalls on any unexpected result.
- Latency:
  - Request accepted at cycle T; earliest wk_va_vld_o at T+1.
  - Walker result at cycle R produces rsp_vld_o at R+1.
  - Earliest next issue is the cycle after the response handshake.
- wk_va_vld_o is never asserted while wk_stall_i=1.
- Fault propagates unchanged; rsp_pa_o carries wk_pa_i even when faulted.

Optional Feature:
- Macro: WALK_REQ_TIMEOUT_EN.
- Enabled:
  - A counter runs in WAIT and clears on leaving WAIT.
  - When the counter reaches TIMEOUT_CYC, go to RESP with rsp_fault_o=1, rsp_pa_o=0 and the in-flight ID; set timeout_o (cleared only by reset); set the drop flag.
  - While the drop flag is set: wk_pa_rdy_o=1 in ISSUE, the late walker result is consumed and discarded, the flag clears, and no issue occurs until then.
  - A result arriving in the same cycle the counter hits the limit is taken as a normal response, with no timeout.
- Disabled: no counter; timeout_o tied 0; the drop flag is constant 0.

Decomposition:
- Shared package walk_pkg:
  - VA_W=32 and PA_W=32.
  - State enum walk_q_state_e {ISSUE, WAIT, RESP}.
  - Struct walk_req_t {va, id}.
- One sub-module, walk_req_fifo: generic synchronous FIFO of walk_req_t with push/pop/full/empty/count.

Test Plan:
1. Push VA 0x0000_1234 ID 3 into an empty queue; walker handshakes next cycle; walker returns PA 0x0000_5234, fault 0 -> rsp_vld_o one cycle later with rsp_pa_o=0x0000_5234, rsp_id_o=3, rsp_fault_o=0, cnt_o back to 0.
2. Push 5 requests back-to-back with DEPTH=4 and the walker busy -> req_rdy_o=0 after the 4th, cnt_o=4; the 5th is accepted the cycle after the first pop; responses return IDs in order 0..4.
3. Hold wk_stall_i=1 for 3 cycles with the FIFO non-empty -> wk_va_vld_o stays 0; it asserts the first cycle stall drops.
4. Response with rsp_rdy_i=0 for 5 cycles -> rsp_* stable, wk_va_vld_o=0, wk_pa_rdy_o=0; after rsp_rdy_i=1, the next issue follows one cycle later.
5. Walker fault on ID 7 -> rsp_fault_o=1, rsp_id_o=7; the next queued request issues normally.
6. With WALK_REQ_TIMEOUT_EN and TIMEOUT_CYC=8, no walker result -> after 8 WAIT cycles a response with fault=1, PA=0 and timeout_o=1; a late walker result is discarded and is not forwarded as a response.
